// File: rtl/nlfsr_pkg.sv
// Shared types and constants for the NLFSR controller.
//   nlfsr_state_t : controller phase (IDLE, LOAD, INIT, RUN)
//   NLFSR_LEN     : length of the external NLFSR in bits
//   cnt_width()   : phase counter width large enough for every phase length
package nlfsr_pkg;

    localparam int NLFSR_LEN = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_INIT = 2'd2,
        ST_RUN  = 2'd3
    } nlfsr_state_t;

    // Width that holds the longest phase length (seed load, init or word
    // collection) without wrapping.
    function automatic int cnt_width(input int init_cycles, input int word_w);
        int m;
        m = NLFSR_LEN;
        if (init_cycles > m) m = init_cycles;
        if (word_w > m) m = word_w;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/bit_collector.sv
// Serial-to-parallel collector for the NLFSR output stream.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : empty the shift register (stop or new seed)
//   clr_overrun   : clear the sticky overrun flag (new seed)
//   sample_en     : sample 'sample' this cycle
//   sample        : serial input bit (NLFSR a0)
//   rnd_ready     : consumer accepts rnd_data when rnd_valid is high
//   rnd_data      : collected word, first sampled bit in the MSB
//   rnd_valid     : rnd_data holds an unaccepted word
//   overrun       : sticky, set when a sampled bit had to be discarded
module bit_collector #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              clr_overrun,
    input  logic              sample_en,
    input  logic              sample,
    input  logic              rnd_ready,
    output logic [WORD_W-1:0] rnd_data,
    output logic              rnd_valid,
    output logic              overrun
);

    logic [WORD_W-1:0] shreg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              full;
    logic              accept;
    logic              out_free;

    assign full     = (cnt_q == CNT_W'(WORD_W));
    assign accept   = rnd_valid && rnd_ready;
    // The output register can take a new word if it is empty or its
    // current word leaves on this same edge.
    assign out_free = !rnd_valid || rnd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q   <= '0;
            cnt_q     <= '0;
            rnd_data  <= '0;
            rnd_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (accept) begin
                rnd_valid <= 1'b0;
            end
            if (clr_overrun) begin
                overrun <= 1'b0;
            end

            // Clearing wins over a transfer: an aborted word is dropped,
            // while a word already in rnd_data stays until accepted.
            if (clear) begin
                shreg_q <= '0;
                cnt_q   <= '0;
            end else if (full && out_free) begin
                rnd_data  <= shreg_q;
                rnd_valid <= 1'b1;
                // Restart with this cycle's bit so no sample is lost.
                if (sample_en) begin
                    shreg_q <= {{(WORD_W-1){1'b0}}, sample};
                    cnt_q   <= CNT_W'(1);
                end else begin
                    shreg_q <= '0;
                    cnt_q   <= '0;
                end
            end else if (full) begin
                // Output held and collector full: keep the collected word,
                // drop the new bit and flag it.
                if (sample_en) begin
                    overrun <= 1'b1;
                end
            end else if (sample_en) begin
                shreg_q <= {shreg_q[WORD_W-2:0], sample};
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/nlfsr_ctrl.sv
// Controller for an external 17-bit NLFSR random generator.
// Seeds the NLFSR serially, runs the init phase, then collects the output
// bit stream into WORD_W-bit words with a valid/ready interface.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   seed, seed_valid/ready: seed handshake (accepted only in IDLE)
//   stop                  : abort to IDLE (wins over a seed handshake)
//   load, d1              : NLFSR serial seed load select and data bit
//   init                  : NLFSR init-phase select
//   nlfsr_ce              : NLFSR warbler-injection enable
//   a0                    : NLFSR output bit
//   rnd_data, rnd_valid/ready : collected word handshake
//   overrun               : sticky, RUN bits were discarded
//   busy                  : controller not in IDLE
module nlfsr_ctrl
    import nlfsr_pkg::*;
#(
    parameter int INIT_CYCLES = 68,
    parameter int WORD_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NLFSR_LEN-1:0] seed,
    input  logic                 seed_valid,
    output logic                 seed_ready,
    input  logic                 stop,
    output logic                 load,
    output logic                 d1,
    output logic                 init,
    output logic                 nlfsr_ce,
    input  logic                 a0,
    output logic [WORD_W-1:0]    rnd_data,
    output logic                 rnd_valid,
    input  logic                 rnd_ready,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = cnt_width(INIT_CYCLES, WORD_W);

    nlfsr_state_t         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NLFSR_LEN-1:0] seed_sr_q, seed_sr_d;
    logic                 load_d, d1_d, init_d, ce_d;
    logic                 seed_acc;
    logic                 sample_en;

    assign seed_acc  = seed_valid && seed_ready && (state_q == ST_IDLE) && !stop;
    assign sample_en = (state_q == ST_RUN) && !stop;

    // Next state and next registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seed_sr_d = seed_sr_q;
        load_d    = 1'b0;
        d1_d      = 1'b0;
        init_d    = 1'b0;
        ce_d      = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (seed_acc) begin
                        // seed[0] is driven on the first LOAD cycle; the
                        // remaining bits are shifted out LSB first.
                        state_d   = ST_LOAD;
                        cnt_d     = '0;
                        load_d    = 1'b1;
                        d1_d      = seed[0];
                        seed_sr_d = {1'b0, seed[NLFSR_LEN-1:1]};
                    end
                end
                ST_LOAD: begin
                    if (cnt_q == CNT_W'(NLFSR_LEN - 1)) begin
                        state_d = ST_INIT;
                        cnt_d   = '0;
                        init_d  = 1'b1;
                        ce_d    = 1'b1;
                    end else begin
                        cnt_d     = cnt_q + CNT_W'(1);
                        load_d    = 1'b1;
                        d1_d      = seed_sr_q[0];
                        seed_sr_d = seed_sr_q >> 1;
                    end
                end
                ST_INIT: begin
                    ce_d = 1'b1;
                    if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        init_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    ce_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and output register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            seed_sr_q  <= '0;
            load       <= 1'b0;
            d1         <= 1'b0;
            init       <= 1'b0;
            nlfsr_ce   <= 1'b0;
            seed_ready <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            seed_sr_q  <= seed_sr_d;
            load       <= load_d;
            d1         <= d1_d;
            init       <= init_d;
            nlfsr_ce   <= ce_d;
            seed_ready <= (state_d == ST_IDLE);
            busy       <= (state_d != ST_IDLE);
        end
    end

    bit_collector #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_collector (
        .clk         (clk),
        .rst         (rst),
        .clear       (stop || seed_acc),
        .clr_overrun (seed_acc),
        .sample_en   (sample_en),
        .sample      (a0),
        .rnd_ready   (rnd_ready),
        .rnd_data    (rnd_data),
        .rnd_valid   (rnd_valid),
        .overrun     (overrun)
    );

endmodule

// File: tb/tb_nlfsr_ctrl.sv
// Self-checking bench for nlfsr_ctrl: a table of seed/pattern vectors,
// directed corner sequences and randomized runs, all compared every cycle
// against a cycle-count/queue based reference model.
module tb_nlfsr_ctrl;

    localparam int IC     = 68;
    localparam int W      = 32;
    localparam int LEN    = 17;
    localparam int RUN_AT = LEN + IC;

    logic           clk = 1'b0;
    logic           rst;
    logic [LEN-1:0] seed;
    logic           seed_valid;
    logic           seed_ready;
    logic           stop;
    logic           load;
    logic           d1;
    logic           init;
    logic           nlfsr_ce;
    logic           a0;
    logic [W-1:0]   rnd_data;
    logic           rnd_valid;
    logic           rnd_ready;
    logic           overrun;
    logic           busy;

    always #5 clk = ~clk;

    nlfsr_ctrl #(.INIT_CYCLES(IC), .WORD_W(W)) dut (
        .clk(clk), .rst(rst), .seed(seed), .seed_valid(seed_valid),
        .seed_ready(seed_ready), .stop(stop), .load(load), .d1(d1),
        .init(init), .nlfsr_ce(nlfsr_ce), .a0(a0), .rnd_data(rnd_data),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .overrun(overrun),
        .busy(busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: m_c counts cycles since the seed was accepted, so
    // the phase follows directly from the phase lengths.
    bit           m_active;
    int           m_c;
    logic [LEN-1:0] m_seed;
    bit           m_coll[$];
    bit           m_vld;
    logic [W-1:0] m_word;
    bit           m_ovr;

    typedef struct {
        logic [LEN-1:0] seed;
        logic [1:0]     pat;      // pat[1] is the first RUN bit, then pat[0]
        logic [W-1:0]   exp_word;
    } vec_t;

    vec_t vecs[4];
    int   exp033[17] = '{1,0,1,0,0,0,1,0,1,1,0,0,0,1,0,0,1};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_c      = 0;
        m_seed   = '0;
        m_coll.delete();
        m_vld    = 0;
        m_word   = '0;
        m_ovr    = 0;
    endtask

    function automatic logic [W-1:0] pack_coll();
        logic [W-1:0] w;
        w = '0;
        foreach (m_coll[k]) w = {w[W-2:0], m_coll[k]};
        return w;
    endfunction

    // Advance the model across the next rising edge using current inputs.
    task automatic model_next();
        bit old_vld, acc, samp;
        old_vld = m_vld;
        acc     = m_vld && rnd_ready;
        if (acc) m_vld = 0;
        if (stop) begin
            m_active = 0;
            m_coll.delete();
        end else if (!m_active) begin
            if (seed_valid) begin
                m_active = 1;
                m_c      = 0;
                m_seed   = seed;
                m_coll.delete();
                m_ovr    = 0;
            end
        end else begin
            samp = (m_c >= RUN_AT);
            if (m_coll.size() == W && (!old_vld || acc)) begin
                m_word = pack_coll();
                m_vld  = 1;
                m_coll.delete();
                if (samp) m_coll.push_back(a0);
            end else if (m_coll.size() == W) begin
                if (samp) m_ovr = 1;
            end else if (samp) begin
                m_coll.push_back(a0);
            end
            m_c++;
        end
    endtask

    task automatic compare_all();
        logic ld, it, ce, dd;
        ld = m_active && (m_c < LEN);
        it = m_active && (m_c >= LEN) && (m_c < RUN_AT);
        ce = m_active && (m_c >= LEN);
        dd = ld ? m_seed[m_c] : 1'b0;
        chk("load", load, ld);
        chk("d1", d1, dd);
        chk("init", init, it);
        chk("nlfsr_ce", nlfsr_ce, ce);
        chk("busy", busy, m_active);
        chk("seed_ready", seed_ready, !m_active);
        chk("rnd_valid", rnd_valid, m_vld);
        chk("rnd_data", rnd_data, m_word);
        chk("overrun", overrun, m_ovr);
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic accept_seed(input logic [LEN-1:0] s);
        seed       = s;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
    endtask

    task automatic count_load(output int n, output logic [LEN-1:0] bits);
        n    = 0;
        bits = '0;
        for (int g = 0; g < 100 && load === 1'b1; g++) begin
            if (n < LEN) bits[n] = d1;
            n++;
            tick();
        end
    endtask

    task automatic count_init(output int n);
        n = 0;
        for (int g = 0; g < 2000 && init === 1'b1; g++) begin
            n++;
            tick();
        end
    endtask

    task automatic go_idle();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        rnd_ready = 1'b1;
        tick();
        rnd_ready = 1'b0;
    endtask

    initial begin
        int             n, first, second, rises;
        logic [LEN-1:0] bits;
        logic [W-1:0]   w1, w2;
        logic           b;
        bit             saw_valid;

        vecs[0] = '{seed: 17'h1_2345, pat: 2'b10, exp_word: 32'hAAAA_AAAA};
        vecs[1] = '{seed: 17'h1_FFFF, pat: 2'b01, exp_word: 32'h5555_5555};
        vecs[2] = '{seed: 17'h0_0000, pat: 2'b11, exp_word: 32'hFFFF_FFFF};
        vecs[3] = '{seed: 17'h1_0001, pat: 2'b00, exp_word: 32'h0000_0000};

        rst = 1'b1; seed = '0; seed_valid = 1'b0; stop = 1'b0;
        a0 = 1'b0; rnd_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        chk("rst_seed_ready", seed_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();

        // Table-driven seed/pattern vectors.
        for (int i = 0; i < 4; i++) begin
            accept_seed(vecs[i].seed);
            count_load(n, bits);
            chk("load_len", n, LEN);
            chk("d1_seq", bits, vecs[i].seed);
            if (i == 0) begin
                for (int k = 0; k < LEN; k++) chk("d1_ref_seq", bits[k], exp033[k]);
            end
            count_init(n);
            chk("init_len", n, IC);
            rises = 0; first = -1; second = -1;
            rnd_ready = 1'b1;
            for (int j = 0; j < 200 && rises < 2; j++) begin
                if (rnd_valid === 1'b1) begin
                    if (rises == 0) first = j; else second = j;
                    chk("word", rnd_data, vecs[i].exp_word);
                    rises++;
                end
                a0 = (j % 2 == 0) ? vecs[i].pat[1] : vecs[i].pat[0];
                tick();
            end
            chk("first_valid_lat", first, W + 1);
            chk("second_valid_lat", second, 2 * W + 1);
            go_idle();
        end

        // Output held for 100 RUN cycles: overrun and word preservation.
        accept_seed(17'h0_ACE1);
        count_load(n, bits);
        count_init(n);
        rnd_ready = 1'b0;
        w1 = '0; w2 = '0;
        for (int j = 0; j < 100; j++) begin
            if (j == 33) begin
                chk("hold_first_valid", rnd_valid, 1'b1);
                chk("hold_first_word", rnd_data, w1);
            end
            if (j > 33) chk("hold_stable", {rnd_valid, rnd_data}, {1'b1, w1});
            if (j == 64) chk("overrun_before", overrun, 1'b0);
            if (j == 65) chk("overrun_after", overrun, 1'b1);
            b = 1'($urandom_range(0, 1));
            a0 = b;
            if (j < 32) w1 = {w1[W-2:0], b};
            else if (j < 64) w2 = {w2[W-2:0], b};
            tick();
        end
        rnd_ready = 1'b1;
        tick();
        chk("next_word_valid", rnd_valid, 1'b1);
        chk("next_word", rnd_data, w2);
        rnd_ready = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_keeps_word", rnd_data, w2);
        chk("stop_keeps_overrun", overrun, 1'b1);
        go_idle();

        // Stop on LOAD cycle 5, then a fresh seed restarts from bit 0.
        accept_seed(17'h1_5A5B);
        repeat (5) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_load", load, 1'b0);
        chk("stop_seed_ready", seed_ready, 1'b1);
        accept_seed(17'h0_A5A4);
        chk("restart_d1_k0", d1, 1'b0);
        count_load(n, bits);
        chk("restart_load_len", n, LEN);
        chk("restart_d1_seq", bits, 17'h0_A5A4);
        go_idle();

        // stop beats a simultaneous seed handshake in IDLE.
        seed = 17'h1_1111; seed_valid = 1'b1; stop = 1'b1;
        tick();
        seed_valid = 1'b0; stop = 1'b0;
        chk("stop_seed_busy", busy, 1'b0);
        chk("stop_seed_load", load, 1'b0);
        tick();
        chk("stop_seed_idle", seed_ready, 1'b1);

        // Asynchronous reset in the middle of INIT.
        accept_seed(17'h0_7777);
        count_load(n, bits);
        repeat (10) tick();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("arst_init", init, 1'b0);
        chk("arst_ce", nlfsr_ce, 1'b0);
        chk("arst_seed_ready", seed_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        rnd_ready = 1'b1;
        saw_valid = 0;
        for (int j = 0; j < 150; j++) begin
            a0 = 1'($urandom_range(0, 1));
            tick();
            if (rnd_valid === 1'b1) saw_valid = 1;
        end
        chk("arst_no_valid", saw_valid, 1'b0);

        // Randomized runs with random backpressure and a random stop point.
        for (int r = 0; r < 4; r++) begin
            accept_seed(17'($urandom()));
            n = $urandom_range(60, 420);
            for (int j = 0; j < n; j++) begin
                a0 = 1'($urandom_range(0, 1));
                rnd_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
            rnd_ready = 1'($urandom_range(0, 1));
            stop = 1'b1;
            tick();
            stop = 1'b0;
            for (int j = 0; j < 4; j++) begin
                rnd_ready = 1'($urandom_range(0, 1));
                tick();
            end
            go_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
